key_schedule_controller: RTL and testbench

Iterative AES-128 key-schedule engine and round-key store. It accepts a cipher key through a valid/ready handshake and generates one round key per clock into an internal 11-entry bank. It then serves round keys to the round datapath through an indexed, registered read port. A consumer lock stops a new key from overwriting the bank while a cipher operation is using it.

---
 rtl/key_schedule_controller.sv | 181 ++++++++++++++++++
 tb/tb_key_schedule_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_controller.sv
// Iterative AES-128 key expansion into an 11-entry round-key bank, with a
// registered indexed read port and a consumer lock that blocks reloads.
module key_schedule_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_WIDTH  = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 keyValid,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 keyReady,
  output logic                 keysValid,
  input  logic                 inUse,
  input  logic                 rdEn,
  input  logic [3:0]           rdIndex,
  output logic [KEY_WIDTH-1:0] rdKey,
  output logic                 rdValid,
  output logic                 rdError
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t               state_r, state_next_s;
  logic [3:0]           round_r;
  logic [KEY_WIDTH-1:0] bank_r [0:NUM_ROUNDS];
  logic                 keys_valid_r;
  logic [KEY_WIDTH-1:0] rd_key_r;
  logic                 rd_valid_r, rd_error_r;
  logic                 key_ready_s, accept_s;
  logic [KEY_WIDTH-1:0] prev_key_s, next_key_s;
  logic [31:0]          temp_s, nw0_s, nw1_s, nw2_s, nw3_s;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine transform of the GF(2^8) inverse, with the inverse taken as x^254
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Next-state and handshake decode
  always_comb begin
    state_next_s = state_r;
    key_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        key_ready_s = 1'b1;
        if (keyValid) state_next_s = EXPAND;
        else          state_next_s = IDLE;
      end
      EXPAND: begin
        key_ready_s = 1'b0;
        if (round_r == LAST_ROUND) state_next_s = READY;
        else                       state_next_s = EXPAND;
      end
      READY: begin
        key_ready_s = !inUse;
        if (keyValid && !inUse) state_next_s = EXPAND;
        else                    state_next_s = READY;
      end
      default: begin
        state_next_s = IDLE;
        key_ready_s  = 1'b0;
      end
    endcase
  end

  assign accept_s = keyValid && key_ready_s;

  // One FIPS-197 round of the key schedule from the previously written entry
  always_comb begin
    if (round_r != 4'd0) prev_key_s = bank_r[round_r - 4'd1];
    else                 prev_key_s = bank_r[0];
    temp_s     = sub_word({prev_key_s[23:0], prev_key_s[31:24]}) ^ {rcon(round_r), 24'h000000};
    nw0_s      = prev_key_s[127:96] ^ temp_s;
    nw1_s      = prev_key_s[95:64]  ^ nw0_s;
    nw2_s      = prev_key_s[63:32]  ^ nw1_s;
    nw3_s      = prev_key_s[31:0]   ^ nw2_s;
    next_key_s = {nw0_s, nw1_s, nw2_s, nw3_s};
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Round counter: 1..10 during expansion, parked at 0 otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                          round_r <= 4'd0;
    else if (accept_s)                                   round_r <= 4'd1;
    else if (state_r == EXPAND && round_r != LAST_ROUND) round_r <= round_r + 4'd1;
    else                                                 round_r <= 4'd0;
  end

  // Round-key bank and completion flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) bank_r[i] <= '0;
      keys_valid_r <= 1'b0;
    end else if (accept_s) begin
      bank_r[0]    <= key;
      keys_valid_r <= 1'b0;
    end else if (state_r == EXPAND) begin
      bank_r[round_r] <= next_key_s;
      keys_valid_r    <= (round_r == LAST_ROUND);
    end else begin
      keys_valid_r <= keys_valid_r;
    end
  end

  // Registered read port; sees pre-accept bank and flag on an accept edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_key_r   <= '0;
      rd_valid_r <= 1'b0;
      rd_error_r <= 1'b0;
    end else if (rdEn) begin
      if (rdIndex > LAST_ROUND || !keys_valid_r) begin
        rd_key_r   <= '0;
        rd_valid_r <= 1'b0;
        rd_error_r <= 1'b1;
      end else begin
        rd_key_r   <= bank_r[rdIndex];
        rd_valid_r <= 1'b1;
        rd_error_r <= 1'b0;
      end
    end else begin
      rd_valid_r <= 1'b0;
      rd_error_r <= 1'b0;
    end
  end

  assign keyReady  = key_ready_s;
  assign keysValid = keys_valid_r;
  assign rdKey     = rd_key_r;
  assign rdValid   = rd_valid_r;
  assign rdError   = rd_error_r;

endmodule

// File: tb/tb_key_schedule_controller.sv
// Self-checking bench for key_schedule_controller against a word-recurrence
// AES-128 key-expansion model with randomized keys and read indices.
module tb_key_schedule_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         keyValid;
  logic [127:0] key;
  logic         keyReady;
  logic         keysValid;
  logic         inUse;
  logic         rdEn;
  logic [3:0]   rdIndex;
  logic [127:0] rdKey;
  logic         rdValid;
  logic         rdError;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]   sbox_t [0:255];
  logic [127:0] cur_key;

  key_schedule_controller #(.NUM_ROUNDS(10), .KEY_WIDTH(128)) dut (
    .clock(clock), .reset(reset), .keyValid(keyValid), .key(key),
    .keyReady(keyReady), .keysValid(keysValid), .inUse(inUse),
    .rdEn(rdEn), .rdIndex(rdIndex), .rdKey(rdKey), .rdValid(rdValid),
    .rdError(rdError)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  // Polynomial product then reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (int'(a) << i);
    for (int j = 14; j >= 8; j--) if (acc[j]) acc = acc ^ (32'h11b << (j - 8));
    return 8'(acc);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    keyValid = 1'b1;
    key      = k;
    tick();
    keyValid = 1'b0;
    cur_key  = k;
  endtask

  task automatic test_reset();
    reset = 1'b0; keyValid = 1'b0; key = '0; inUse = 1'b0; rdEn = 1'b0; rdIndex = 4'd0;
    tick(); tick();
    n_cmp++; if (keysValid !== 1'b0) begin n_err++; $display("FAIL reset_keysValid got=%0b exp=0", keysValid); end
    n_cmp++; if (rdKey !== 128'h0) begin n_err++; $display("FAIL reset_rdKey got=%h exp=0", rdKey); end
    n_cmp++; if (rdValid !== 1'b0 || rdError !== 1'b0) begin n_err++; $display("FAIL reset_rdflags got=%0b%0b exp=00", rdValid, rdError); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (keyReady !== 1'b1) begin n_err++; $display("FAIL reset_keyReady got=%0b exp=1", keyReady); end
  endtask

  task automatic test_unloaded_read();
    rdEn = 1'b1; rdIndex = 4'($urandom_range(0, 10));
    tick();
    n_cmp++; if (rdError !== 1'b1 || rdValid !== 1'b0 || rdKey !== 128'h0) begin n_err++; $display("FAIL unloaded_read got err=%0b val=%0b key=%h exp err=1 val=0 key=0", rdError, rdValid, rdKey); end
    rdEn = 1'b0;
    tick();
    n_cmp++; if (rdError !== 1'b0) begin n_err++; $display("FAIL unloaded_idle got=%0b exp=0", rdError); end
  endtask

  task automatic test_fips();
    logic [127:0] exp_c [0:2];
    logic [3:0]   idx [0:2];
    exp_c[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c; idx[0] = 4'd0;
    exp_c[1] = 128'ha0fafe1788542cb123a339392a6c7605; idx[1] = 4'd1;
    exp_c[2] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; idx[2] = 4'd10;
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    n_cmp++; if (keysValid !== 1'b0 || keyReady !== 1'b0) begin n_err++; $display("FAIL fips_accept got kv=%0b kr=%0b exp 0 0", keysValid, keyReady); end
    for (int i = 1; i < 10; i++) begin
      tick();
      n_cmp++; if (keysValid !== 1'b0) begin n_err++; $display("FAIL fips_early_valid cycle=%0d got=%0b exp=0", i, keysValid); end
    end
    tick();
    n_cmp++; if (keysValid !== 1'b1) begin n_err++; $display("FAIL fips_valid_T10 got=%0b exp=1", keysValid); end
    for (int i = 0; i < 3; i++) begin
      rdEn = 1'b1; rdIndex = idx[i];
      tick();
      n_cmp++; if (rdKey !== exp_c[i] || rdValid !== 1'b1) begin n_err++; $display("FAIL fips_read idx=%0d got=%h v=%0b exp=%h v=1", idx[i], rdKey, rdValid, exp_c[i]); end
    end
    rdEn = 1'b0;
  endtask

  task automatic test_zero_key();
    load_key(128'h0);
    repeat (10) tick();
    rdEn = 1'b1; rdIndex = 4'd10;
    tick();
    n_cmp++; if (rdKey !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_err++; $display("FAIL zero_r10 got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e", rdKey); end
    rdIndex = 4'd11;
    tick();
    n_cmp++; if (rdError !== 1'b1 || rdValid !== 1'b0) begin n_err++; $display("FAIL oob_11 got err=%0b val=%0b exp 1 0", rdError, rdValid); end
    rdIndex = 4'd15;
    tick();
    n_cmp++; if (rdError !== 1'b1 || rdValid !== 1'b0 || rdKey !== 128'h0) begin n_err++; $display("FAIL oob_15 got err=%0b val=%0b key=%h exp 1 0 0", rdError, rdValid, rdKey); end
    rdEn = 1'b0;
  endtask

  task automatic test_expand_hold();
    logic [127:0] ka, kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    keyValid = 1'b1; key = ka;
    tick();
    key = kb;
    n_cmp++; if (keyReady !== 1'b0) begin n_err++; $display("FAIL hold_ready cycle=0 got=%0b exp=0", keyReady); end
    for (int i = 1; i < 10; i++) begin
      tick();
      n_cmp++; if (keyReady !== 1'b0 || keysValid !== 1'b0) begin n_err++; $display("FAIL hold_ready cycle=%0d got kr=%0b kv=%0b exp 0 0", i, keyReady, keysValid); end
    end
    tick();
    n_cmp++; if (keysValid !== 1'b1 || keyReady !== 1'b1) begin n_err++; $display("FAIL hold_done got kv=%0b kr=%0b exp 1 1", keysValid, keyReady); end
    rdEn = 1'b1; rdIndex = 4'd10;
    tick();
    keyValid = 1'b0; rdEn = 1'b0;
    n_cmp++; if (keysValid !== 1'b0) begin n_err++; $display("FAIL second_accept got kv=%0b exp=0", keysValid); end
    n_cmp++; if (rdKey !== model_key(ka, 10) || rdError !== 1'b0 || rdValid !== 1'b1) begin n_err++; $display("FAIL accept_read_old got=%h err=%0b exp=%h err=0", rdKey, rdError, model_key(ka, 10)); end
    repeat (9) tick();
    n_cmp++; if (keysValid !== 1'b0) begin n_err++; $display("FAIL second_early got=%0b exp=0", keysValid); end
    tick();
    n_cmp++; if (keysValid !== 1'b1) begin n_err++; $display("FAIL second_valid got=%0b exp=1", keysValid); end
    cur_key = kb;
    rdEn = 1'b1; rdIndex = 4'd7;
    tick();
    rdEn = 1'b0;
    n_cmp++; if (rdKey !== model_key(kb, 7)) begin n_err++; $display("FAIL second_r7 got=%h exp=%h", rdKey, model_key(kb, 7)); end
  endtask

  task automatic test_in_use();
    logic [127:0] kc;
    kc = {$urandom, $urandom, $urandom, $urandom};
    inUse = 1'b1; keyValid = 1'b1; key = kc;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (keyReady !== 1'b0 || keysValid !== 1'b1) begin n_err++; $display("FAIL inuse_block cycle=%0d got kr=%0b kv=%0b exp 0 1", i, keyReady, keysValid); end
    end
    rdEn = 1'b1; rdIndex = 4'd5;
    tick();
    n_cmp++; if (rdKey !== model_key(cur_key, 5)) begin n_err++; $display("FAIL inuse_r5 got=%h exp=%h", rdKey, model_key(cur_key, 5)); end
    inUse = 1'b0; rdIndex = 4'd3;
    #1;
    n_cmp++; if (keyReady !== 1'b1) begin n_err++; $display("FAIL inuse_release got=%0b exp=1", keyReady); end
    tick();
    keyValid = 1'b0; rdEn = 1'b0;
    n_cmp++; if (keysValid !== 1'b0) begin n_err++; $display("FAIL release_accept got=%0b exp=0", keysValid); end
    n_cmp++; if (rdKey !== model_key(cur_key, 3) || rdError !== 1'b0) begin n_err++; $display("FAIL release_read got=%h err=%0b exp=%h err=0", rdKey, rdError, model_key(cur_key, 3)); end
    cur_key = kc;
    repeat (10) tick();
    rdEn = 1'b1; rdIndex = 4'd5;
    tick();
    rdEn = 1'b0;
    n_cmp++; if (rdKey !== model_key(kc, 5) || keysValid !== 1'b1) begin n_err++; $display("FAIL reload_r5 got=%h exp=%h", rdKey, model_key(kc, 5)); end
  endtask

  task automatic test_back_to_back();
    rdEn = 1'b1; rdIndex = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      tick();
      n_cmp++; if (rdValid !== 1'b1 || rdKey !== model_key(cur_key, i)) begin n_err++; $display("FAIL b2b idx=%0d got=%h v=%0b exp=%h v=1", i, rdKey, rdValid, model_key(cur_key, i)); end
      if (i < 10) rdIndex = 4'(i + 1);
      else        rdEn = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [3:0] ri;
    for (int n = 0; n < 3; n++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      repeat (10) tick();
      n_cmp++; if (keysValid !== 1'b1) begin n_err++; $display("FAIL rand_valid key=%0d got=%0b exp=1", n, keysValid); end
      rdEn = 1'b1;
      for (int j = 0; j < 8; j++) begin
        ri = 4'($urandom_range(0, 15));
        rdIndex = ri;
        tick();
        if (ri > 4'd10) begin
          n_cmp++; if (rdError !== 1'b1 || rdValid !== 1'b0 || rdKey !== 128'h0) begin n_err++; $display("FAIL rand_oob idx=%0d got err=%0b v=%0b exp 1 0", ri, rdError, rdValid); end
        end else begin
          n_cmp++; if (rdKey !== model_key(cur_key, int'(ri)) || rdValid !== 1'b1) begin n_err++; $display("FAIL rand_read idx=%0d got=%h exp=%h", ri, rdKey, model_key(cur_key, int'(ri))); end
        end
      end
      rdEn = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rdEn = 1'b1; rdIndex = 4'd4;
    tick();
    rdEn = 1'b0;
    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (5) tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (keysValid !== 1'b0 || rdKey !== 128'h0 || rdValid !== 1'b0 || rdError !== 1'b0) begin n_err++; $display("FAIL midreset_outputs got kv=%0b key=%h v=%0b e=%0b exp all 0", keysValid, rdKey, rdValid, rdError); end
    n_cmp++; if (keyReady !== 1'b1) begin n_err++; $display("FAIL midreset_idle got=%0b exp=1", keyReady); end
    tick();
    #2 reset = 1'b1;
    rdEn = 1'b1; rdIndex = 4'd0;
    tick();
    rdEn = 1'b0;
    n_cmp++; if (rdError !== 1'b1 || rdValid !== 1'b0) begin n_err++; $display("FAIL midreset_read got err=%0b v=%0b exp 1 0", rdError, rdValid); end
    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (9) tick();
    n_cmp++; if (keysValid !== 1'b0) begin n_err++; $display("FAIL fresh_early got=%0b exp=0", keysValid); end
    tick();
    n_cmp++; if (keysValid !== 1'b1) begin n_err++; $display("FAIL fresh_valid got=%0b exp=1", keysValid); end
    test_back_to_back();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_unloaded_read();
    test_fips();
    test_zero_key();
    test_expand_hold();
    test_in_use();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
